// File: rtl/apb4_reg_slave.sv
// apb4_reg_slave
// APB4 completer with a bank of byte-writable scratch registers, a saturating
// error counter and a read-only ID register. Each access phase is stretched
// by WAIT_STATES cycles. Illegal-access flags from the bridge, misaligned
// addresses, out-of-range indices and writes to ID become PSLVERROR.
//
// Register map (word index = PADDR[ADDR_W-1:2]):
//   0 .. NUM_REGS-1 : scratch RW, reset 0, byte strobed
//   NUM_REGS        : ERR_CNT (bits 15:0), any legal write clears it
//   NUM_REGS+1      : ID (read-only, ID_VALUE)
//
// Ports:
//   PCLK, PRESET              clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE     APB control
//   PADDR[ADDR_W-1:0]         byte offset within peripheral window
//   PWDATA[31:0], PSTRB[3:0]  write data and byte strobes
//   ilac_sec/cid/priv         illegal-access flags, captured in setup
//   PRDATA[31:0]              read data, nonzero only with PREADY
//   PREADY, PSLVERROR         transfer complete / error response
//   irq                       error interrupt
//
// Optional feature: define APB_SLV_IRQ_EN for a registered irq that is high
// while ERR_CNT is nonzero; otherwise irq is tied low.
module apb4_reg_slave #(
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_STATES = 1,
   parameter int          ADDR_W      = 12,
   parameter logic [31:0] ID_VALUE    = 32'hA5B4_0001
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   input  logic [3:0]        PSTRB,
   input  logic              ilac_sec,
   input  logic              ilac_cid,
   input  logic              ilac_priv,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERROR,
   output logic              irq
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [3:0]        WS      = 4'(WAIT_STATES);
   localparam logic [ADDR_W-3:0] IDX_ERR = (ADDR_W-2)'(NUM_REGS);
   localparam logic [ADDR_W-3:0] IDX_ID  = (ADDR_W-2)'(NUM_REGS + 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              write_q, write_d;
   logic              ilac_q, ilac_d;
   logic [31:0]       regs_q [NUM_REGS];
   logic [31:0]       regs_d [NUM_REGS];
   logic [15:0]       err_cnt_q, err_cnt_d;

   logic [ADDR_W-3:0] idx;
   logic              err;
   logic              pready;
   logic              complete;
   logic [31:0]       rd_mux;

   // Decode of the captured transfer
   always_comb begin
      idx      = addr_q[ADDR_W-1:2];
      err      = (addr_q[1:0] != 2'b00) || (idx > IDX_ID) ||
                 (write_q && (idx == IDX_ID)) || ilac_q;
      pready   = (state_q == ACCESS) && PENABLE && (cnt_q == 4'd0);
      complete = pready && PSEL;
      rd_mux   = 32'h0;
      if (idx == IDX_ERR) rd_mux = {16'h0, err_cnt_q};
      if (idx == IDX_ID)  rd_mux = ID_VALUE;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == (ADDR_W-2)'(i)) rd_mux = regs_q[i];
      end
   end

   assign PREADY    = pready;
   assign PSLVERROR = pready && err;
   assign PRDATA    = (pready && !write_q && !err) ? rd_mux : 32'h0;

   // Next-state: FSM, wait counter, register writes, error counter
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      ilac_d    = ilac_q;
      regs_d    = regs_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ACCESS;
               cnt_d   = WS;
               addr_d  = PADDR;
               write_d = PWRITE;
               ilac_d  = ilac_sec | ilac_cid | ilac_priv;
            end
         end
         ACCESS: begin
            // Dropping PSEL mid-access abandons the transfer with no side effects
            if (!PSEL || complete) state_d = IDLE;
            else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      // An erroring transfer only counts; it never writes, even to ERR_CNT
      if (complete && err) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end else if (complete && write_q) begin
         if (idx == IDX_ERR) err_cnt_d = 16'h0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == (ADDR_W-2)'(i)) begin
               for (int k = 0; k < 4; k++) begin
                  if (PSTRB[k]) regs_d[i][8*k +: 8] = PWDATA[8*k +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         ilac_q    <= 1'b0;
         err_cnt_q <= 16'h0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         ilac_q    <= ilac_d;
         err_cnt_q <= err_cnt_d;
         regs_q    <= regs_d;
      end
   end

`ifdef APB_SLV_IRQ_EN
   logic irq_q, irq_d;

   // Follows ERR_CNT one cycle late
   always_comb irq_d = (err_cnt_q != 16'h0);

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_reg_slave.sv
module tb_apb4_reg_slave;

   localparam int ADDR_W = 12;
`ifdef APB_SLV_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic              PSEL = 1'b0;
   logic              PENABLE = 1'b0;
   logic              PWRITE = 1'b0;
   logic [ADDR_W-1:0] PADDR = '0;
   logic [31:0]       PWDATA = 32'h0;
   logic [3:0]        PSTRB = 4'h0;
   logic              ilac_sec = 1'b0;
   logic              ilac_cid = 1'b0;
   logic              ilac_priv = 1'b0;
   logic [31:0]       PRDATA;
   logic              PREADY;
   logic              PSLVERROR;
   logic              irq;

   int checks = 0;
   int failures = 0;

   apb4_reg_slave #(
      .NUM_REGS(8), .WAIT_STATES(2), .ADDR_W(ADDR_W), .ID_VALUE(32'hA5B4_0001)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .ilac_sec(ilac_sec), .ilac_cid(ilac_cid), .ilac_priv(ilac_priv),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // One APB transfer starting in the current cycle. Returns the captured
   // response and the cycle (relative to setup) in which PREADY was seen.
   // Leaves the bus idle in the cycle after completion so a new transfer may
   // start immediately.
   task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic ip, output logic [31:0] rdata,
                       output logic serr, output int lat);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
      PWDATA = wdata; PSTRB = strb; ilac_priv = ip;
      lat = 0;
      step();
      PENABLE = 1'b1; ilac_priv = 1'b0;
      lat = 1;
      while (!PREADY && lat < 20) begin
         step();
         lat++;
      end
      rdata = PRDATA;
      serr  = PSLVERROR;
      step();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      if (PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
      checks++;
      if (PREADY !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
      checks++;
      if (PSLVERROR !== 1'b0) begin failures++; $display("FAIL reset_pslverror got=%b exp=0", PSLVERROR); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++;
   endtask

   task automatic test_wait_write_read();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b1, 12'h004, 32'h1234_5678, 4'hF, 1'b0, rd, e, lat);
      if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", e); end
      checks++;
      if (PREADY !== 1'b0) begin failures++; $display("FAIL pready_one_cycle got=%b exp=0", PREADY); end
      checks++;
      xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h1234_5678) begin failures++; $display("FAIL rd_reg1 got=%h exp=12345678", rd); end
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL rd_reg1_err got=%b exp=0", e); end
      checks++;
   endtask

   task automatic test_strobe();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b1, 12'h008, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, e, lat);
      xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h00BB_00DD) begin failures++; $display("FAIL strobe_0101 got=%h exp=00bb00dd", rd); end
      checks++;
      xfer(1'b1, 12'h008, 32'h1111_1111, 4'h0, 1'b0, rd, e, lat);
      if (e !== 1'b0) begin failures++; $display("FAIL strobe0_err got=%b exp=0", e); end
      checks++;
      xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h00BB_00DD) begin failures++; $display("FAIL strobe0_noop got=%h exp=00bb00dd", rd); end
      checks++;
   endtask

   task automatic test_id_err();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b0, 12'h024, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'hA5B4_0001) begin failures++; $display("FAIL id_read got=%h exp=a5b40001", rd); end
      checks++;
      xfer(1'b1, 12'h024, 32'h5555_5555, 4'hF, 1'b0, rd, e, lat);
      if (e !== 1'b1) begin failures++; $display("FAIL id_write_err got=%b exp=1", e); end
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_not_yet got=%b exp=0", irq); end
      checks++;
      step();
      if (irq !== IRQ_ON) begin failures++; $display("FAIL irq_set got=%b exp=%b", irq, IRQ_ON); end
      checks++;
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h1) begin failures++; $display("FAIL errcnt_1 got=%h exp=1", rd); end
      checks++;
      xfer(1'b0, 12'h024, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'hA5B4_0001) begin failures++; $display("FAIL id_unchanged got=%h exp=a5b40001", rd); end
      checks++;
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, e, lat);
      if (e !== 1'b1) begin failures++; $display("FAIL misaligned_err got=%b exp=1", e); end
      checks++;
      xfer(1'b0, 12'h040, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (e !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", e); end
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL oor_prdata got=%h exp=0", rd); end
      checks++;
      xfer(1'b0, 12'h028, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (e !== 1'b1) begin failures++; $display("FAIL idx10_err got=%b exp=1", e); end
      checks++;
      xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (e !== 1'b0) begin failures++; $display("FAIL last_scratch_err got=%b exp=0", e); end
      checks++;
      xfer(1'b0, 12'h004, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h1234_5678) begin failures++; $display("FAIL misaligned_nowrite got=%h exp=12345678", rd); end
      checks++;
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h4) begin failures++; $display("FAIL errcnt_4 got=%h exp=4", rd); end
      checks++;
      xfer(1'b1, 12'h022, 32'h0, 4'hF, 1'b0, rd, e, lat);
      if (e !== 1'b1) begin failures++; $display("FAIL bad_clear_err got=%b exp=1", e); end
      checks++;
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h5) begin failures++; $display("FAIL errcnt_5 got=%h exp=5", rd); end
      checks++;
      xfer(1'b1, 12'h020, 32'h0, 4'hF, 1'b0, rd, e, lat);
      if (e !== 1'b0) begin failures++; $display("FAIL clear_err got=%b exp=0", e); end
      checks++;
      step();
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got=%b exp=0", irq); end
      checks++;
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h0) begin failures++; $display("FAIL errcnt_cleared got=%h exp=0", rd); end
      checks++;
   endtask

   task automatic test_ilac();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b1, 12'h000, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, e, lat);
      if (e !== 1'b1) begin failures++; $display("FAIL ilac_err got=%b exp=1", e); end
      checks++;
      xfer(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h0) begin failures++; $display("FAIL ilac_nowrite got=%h exp=0", rd); end
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL ilac_clean_read got=%b exp=0", e); end
      checks++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic e; int lat;
      xfer(1'b1, 12'h01C, 32'hCAFE_F00D, 4'hF, 1'b0, rd, e, lat);
      xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (lat !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
      checks++;
      if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_read got=%h exp=cafef00d", rd); end
      checks++;
   endtask

   task automatic test_abort_reset();
      logic [31:0] rd; logic e; int lat;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C;
      PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
      step();
      PENABLE = 1'b1;
      if (PREADY !== 1'b0) begin failures++; $display("FAIL abort_wait_pready got=%b exp=0", PREADY); end
      checks++;
      step();
      PSEL = 1'b0; PENABLE = 1'b0;
      step();
      xfer(1'b0, 12'h00C, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h0) begin failures++; $display("FAIL abort_nowrite got=%h exp=0", rd); end
      checks++;
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h1) begin failures++; $display("FAIL abort_errcnt got=%h exp=1", rd); end
      checks++;
      // Reset in the final access cycle of a write
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h010;
      PWDATA = 32'h0BAD_CAFE; PSTRB = 4'hF;
      step();
      PENABLE = 1'b1;
      step();
      step();
      PRESET = 1'b1;
      #1;
      if ({PRDATA, PREADY, PSLVERROR, irq} !== 35'h0) begin
         failures++; $display("FAIL reset_mid_outputs got=%h/%b/%b/%b exp=0", PRDATA, PREADY, PSLVERROR, irq);
      end
      checks++;
      step();
      if (PREADY !== 1'b0) begin failures++; $display("FAIL reset_held_pready got=%b exp=0", PREADY); end
      checks++;
      PSEL = 1'b0; PENABLE = 1'b0;
      PRESET = 1'b0;
      step();
      xfer(1'b0, 12'h010, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h0) begin failures++; $display("FAIL reset_discard_write got=%h exp=0", rd); end
      checks++;
      xfer(1'b0, 12'h01C, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h0) begin failures++; $display("FAIL reset_clears_regs got=%h exp=0", rd); end
      checks++;
      xfer(1'b0, 12'h020, 32'h0, 4'h0, 1'b0, rd, e, lat);
      if (rd !== 32'h0) begin failures++; $display("FAIL reset_clears_errcnt got=%h exp=0", rd); end
      checks++;
   endtask

   initial begin
      PRESET = 1'b1;
      step();
      step();
      test_reset();
      PRESET = 1'b0;
      step();
      test_wait_write_read();
      test_strobe();
      test_id_err();
      test_errors();
      test_ilac();
      test_back_to_back();
      test_abort_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
